// File: rtl/soc_noc_class_demux.sv
`default_nettype none
// ============================================================================
//  Module      : soc_noc_class_demux
//  Description : NoC packet demultiplexer. Decodes the CLASS field of each
//                header flit and steers the whole packet to the matching
//                output channel through a one-entry output register.
//                Oversize packets are truncated and packets with an
//                unmapped class are dropped; both raise a one-cycle error.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_noc_class_demux #(
    parameter int FLIT_WIDTH = 32,
    parameter int MAX_LEN    = 32,
    parameter int CLASS_MSB  = 26,
    parameter int CLASS_LSB  = 24,
    parameter int CHANNELS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
    output logic                  err_oversize,
    output logic                  err_class
);

    localparam int CW    = CLASS_MSB - CLASS_LSB + 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [CW-1:0]         sel_q,       sel_d;
    logic [CHANNELS-1:0]   out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q,  out_flit_d;
    logic                  out_last_q,  out_last_d;
    logic                  err_ovs_q,   err_ovs_d;
    logic                  err_cls_q,   err_cls_d;

    logic [CW-1:0]         w_cls;
    logic [CHANNELS-1:0]   w_hdr_oh;
    logic [CHANNELS-1:0]   w_sel_oh;
    logic                  w_cls_ok;
    logic                  w_ov;
    logic                  w_drain;
    logic                  w_in_ready;
    logic                  w_accept;

    assign w_cls = in_flit[CLASS_MSB:CLASS_LSB];

    // One-hot decode of the incoming class and of the latched channel.
    // A class with no decode bit set is unmapped.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_decode
            assign w_hdr_oh[gi] = (w_cls == CW'(gi));
            assign w_sel_oh[gi] = (sel_q == CW'(gi));
        end
    endgenerate

    assign w_cls_ok = |w_hdr_oh;

    // The valid vector is one-hot on sel, so masking ready with it selects
    // out_ready[sel] without an index wider than the ready vector.
    assign w_ov       = |out_valid_q;
    assign w_drain    = |(out_valid_q & out_ready);
    assign w_in_ready = (state_q == S_DROP) | ~w_ov | w_drain;
    assign w_accept   = in_valid & w_in_ready;

    // Next-state: FSM, output-register load/drain and error pulses.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sel_d       = sel_q;
        out_valid_d = w_drain ? '0 : out_valid_q;
        out_flit_d  = out_flit_q;
        out_last_d  = out_last_q;
        err_ovs_d   = 1'b0;
        err_cls_d   = 1'b0;

        if (w_accept) begin
            case (state_q)
                S_IDLE: begin
                    if (w_cls_ok) begin
                        out_valid_d = w_hdr_oh;
                        out_flit_d  = in_flit;
                        out_last_d  = in_last;
                        sel_d       = w_cls;
                        count_d     = CNT_W'(1);
                        state_d     = in_last ? S_IDLE : S_FWD;
                    end else begin
                        err_cls_d   = 1'b1;
                        state_d     = in_last ? S_IDLE : S_DROP;
                    end
                end
                S_FWD: begin
                    out_valid_d = w_sel_oh;
                    out_flit_d  = in_flit;
                    count_d     = count_q + CNT_W'(1);
                    if (in_last) begin
                        out_last_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (count_q == CNT_W'(MAX_LEN - 1)) begin
                        // MAX_LEN-th flit: close the packet here, discard the rest
                        out_last_d = 1'b1;
                        err_ovs_d  = 1'b1;
                        state_d    = S_DROP;
                    end else begin
                        out_last_d = 1'b0;
                    end
                end
                S_DROP: begin
                    if (in_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            sel_q       <= '0;
            out_valid_q <= '0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            err_ovs_q   <= 1'b0;
            err_cls_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
            err_ovs_q   <= err_ovs_d;
            err_cls_q   <= err_cls_d;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_flit     = out_flit_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign err_oversize = err_ovs_q;
    assign err_class    = err_cls_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_noc_class_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_noc_class_demux
//  Description : Self-checking bench for soc_noc_class_demux (5 channels,
//                MAX_LEN 32). Vector table plus hand-written sequences for
//                truncation, exact-length packets and mid-packet reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_noc_class_demux;

    localparam int FW = 32;
    localparam int CH = 5;
    localparam int ML = 32;

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] in_flit;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic [CH-1:0] out_valid;
    logic [CH-1:0] out_ready;
    logic          err_oversize;
    logic          err_class;

    int checks   = 0;
    int failures = 0;
    logic pre_ir;

    soc_noc_class_demux #(
        .FLIT_WIDTH (FW),
        .MAX_LEN    (ML),
        .CLASS_MSB  (26),
        .CLASS_LSB  (24),
        .CHANNELS   (CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_flit      (in_flit),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_oversize (err_oversize),
        .err_class    (err_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        logic          last;
        logic          valid;
        logic [CH-1:0] rdy;
        logic          e_ir;
        logic [CH-1:0] e_ov;
        logic [FW-1:0] e_flit;
        logic          e_last;
        logic          e_eo;
        logic          e_ec;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mv(input logic [FW-1:0] f, input logic l, input logic v,
                                input logic [CH-1:0] r, input logic ir, input logic [CH-1:0] ov,
                                input logic [FW-1:0] ef, input logic el, input logic eo,
                                input logic ec);
        vec_t t;
        t.flit = f; t.last = l; t.valid = v; t.rdy = r;
        t.e_ir = ir; t.e_ov = ov; t.e_flit = ef; t.e_last = el; t.e_eo = eo; t.e_ec = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample in_ready before the edge,
    // leave registered outputs ready to sample 1ns after the edge.
    task automatic cyc(input logic [FW-1:0] f, input logic l, input logic v, input logic [CH-1:0] r);
        @(negedge clk);
        in_flit = f; in_last = l; in_valid = v; out_ready = r;
        #1;
        pre_ir = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [CH-1:0] ov, input logic [FW-1:0] f,
                           input logic l, input logic eo, input logic ec);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " out_flit"}, out_flit, f);
        chk({tag, " out_last"}, 32'(out_last), 32'(l));
        chk({tag, " err_oversize"}, 32'(err_oversize), 32'(eo));
        chk({tag, " err_class"}, 32'(err_class), 32'(ec));
    endtask

    initial begin
        logic [FW-1:0] f;
        int eo_cnt;

        // ------------------------------------------------------------------
        // Vector table
        // ------------------------------------------------------------------
        // class 2, 3 flits, all ready
        vecs[0]  = mv(32'h0200A000, 0, 1, 5'h1F, 1, 5'h04, 32'h0200A000, 0, 0, 0);
        vecs[1]  = mv(32'h11110001, 0, 1, 5'h1F, 1, 5'h04, 32'h11110001, 0, 0, 0);
        vecs[2]  = mv(32'h22220002, 1, 1, 5'h1F, 1, 5'h04, 32'h22220002, 1, 0, 0);
        vecs[3]  = mv(32'h0,        0, 0, 5'h1F, 1, 5'h00, 32'h22220002, 1, 0, 0);
        // back-to-back single-flit packets, class 1 then 3
        vecs[4]  = mv(32'h01000B01, 1, 1, 5'h1F, 1, 5'h02, 32'h01000B01, 1, 0, 0);
        vecs[5]  = mv(32'h03000C03, 1, 1, 5'h1F, 1, 5'h08, 32'h03000C03, 1, 0, 0);
        vecs[6]  = mv(32'h0,        0, 0, 5'h1F, 1, 5'h00, 32'h03000C03, 1, 0, 0);
        // unmapped class 6, 4 flits all consumed, nothing forwarded
        vecs[7]  = mv(32'h0600D000, 0, 1, 5'h1F, 1, 5'h00, 32'h03000C03, 1, 0, 1);
        vecs[8]  = mv(32'hDDDD0001, 0, 1, 5'h1F, 1, 5'h00, 32'h03000C03, 1, 0, 0);
        vecs[9]  = mv(32'hDDDD0002, 0, 1, 5'h1F, 1, 5'h00, 32'h03000C03, 1, 0, 0);
        vecs[10] = mv(32'hDDDD0003, 1, 1, 5'h1F, 1, 5'h00, 32'h03000C03, 1, 0, 0);
        // highest mapped class 4, then lowest unmapped class 5
        vecs[11] = mv(32'h0400E004, 1, 1, 5'h1F, 1, 5'h10, 32'h0400E004, 1, 0, 0);
        vecs[12] = mv(32'h0500F005, 1, 1, 5'h1F, 1, 5'h00, 32'h0400E004, 1, 0, 1);
        vecs[13] = mv(32'h0,        0, 0, 5'h1F, 1, 5'h00, 32'h0400E004, 1, 0, 0);
        // stall: out_ready[2]=0 for 4 cycles mid-packet, other readies high
        vecs[14] = mv(32'h02006000, 0, 1, 5'h1F, 1, 5'h04, 32'h02006000, 0, 0, 0);
        vecs[15] = mv(32'h66660001, 0, 1, 5'h1B, 0, 5'h04, 32'h02006000, 0, 0, 0);
        vecs[16] = mv(32'h66660001, 0, 1, 5'h1B, 0, 5'h04, 32'h02006000, 0, 0, 0);
        vecs[17] = mv(32'h66660001, 0, 1, 5'h1B, 0, 5'h04, 32'h02006000, 0, 0, 0);
        vecs[18] = mv(32'h66660001, 0, 1, 5'h1B, 0, 5'h04, 32'h02006000, 0, 0, 0);
        vecs[19] = mv(32'h66660001, 0, 1, 5'h1F, 1, 5'h04, 32'h66660001, 0, 0, 0);
        vecs[20] = mv(32'h66660002, 0, 1, 5'h1F, 1, 5'h04, 32'h66660002, 0, 0, 0);
        vecs[21] = mv(32'h66660003, 1, 1, 5'h1F, 1, 5'h04, 32'h66660003, 1, 0, 0);
        vecs[22] = mv(32'h0,        0, 0, 5'h1F, 1, 5'h00, 32'h66660003, 1, 0, 0);

        // ------------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------------
        rst_n = 1'b0; in_flit = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk_out("reset", 5'h00, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ------------------------------------------------------------------
        // Table-driven vectors
        // ------------------------------------------------------------------
        for (int k = 0; k < NV; k++) begin
            cyc(vecs[k].flit, vecs[k].last, vecs[k].valid, vecs[k].rdy);
            chk($sformatf("vec%0d in_ready", k), 32'(pre_ir), 32'(vecs[k].e_ir));
            chk_out($sformatf("vec%0d", k), vecs[k].e_ov, vecs[k].e_flit,
                    vecs[k].e_last, vecs[k].e_eo, vecs[k].e_ec);
        end

        // ------------------------------------------------------------------
        // 40-flit packet truncated at 32; tail dropped while output stalled
        // ------------------------------------------------------------------
        eo_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            f = (i == 0) ? 32'h00003000 : (32'hA5000000 + 32'(i));
            cyc(f, (i == 39), 1'b1, (i < 32) ? 5'h1F : 5'h00);
            if (err_oversize) eo_cnt++;
            chk($sformatf("ovs%0d in_ready", i), 32'(pre_ir), 32'h1);
            if (i < 32)
                chk_out($sformatf("ovs%0d", i), 5'h01, f, (i == 31), (i == 31), 0);
            else
                chk_out($sformatf("ovs%0d", i), 5'h01, 32'hA500001F, 1, 0, 0);
        end
        cyc(32'h0, 0, 0, 5'h1F);
        if (err_oversize) eo_cnt++;
        chk_out("ovs drain", 5'h00, 32'hA500001F, 1, 0, 0);
        chk("ovs pulse count", 32'(eo_cnt), 32'h1);

        // next packet after truncation: class 3, 2 flits
        cyc(32'h03000001, 0, 1, 5'h1F);
        chk_out("post0", 5'h08, 32'h03000001, 0, 0, 0);
        cyc(32'hB0B00002, 1, 1, 5'h1F);
        chk_out("post1", 5'h08, 32'hB0B00002, 1, 0, 0);

        // ------------------------------------------------------------------
        // Exactly MAX_LEN flits: passes without error
        // ------------------------------------------------------------------
        for (int i = 0; i < ML; i++) begin
            f = (i == 0) ? 32'h01000000 : (32'hC0000000 + 32'(i));
            cyc(f, (i == ML - 1), 1'b1, 5'h1F);
            chk_out($sformatf("exact%0d", i), 5'h02, f, (i == ML - 1), 0, 0);
        end
        cyc(32'h0, 0, 0, 5'h1F);
        chk_out("exact drain", 5'h00, 32'hC000001F, 1, 0, 0);

        // ------------------------------------------------------------------
        // Reset asserted mid-FWD, next flit must be treated as a header
        // ------------------------------------------------------------------
        cyc(32'h02007000, 0, 1, 5'h1F);
        cyc(32'h77770001, 0, 1, 5'h1F);
        chk_out("pre-rst", 5'h04, 32'h77770001, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async rst", 5'h00, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(32'h01008001, 1, 1, 5'h1F);
        chk_out("post-rst hdr", 5'h02, 32'h01008001, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
